// File: rtl/ex_stage.sv
// Execute stage with EX/MEM pipeline register.
// Single-cycle ADD/SUB/SLT, iterative MUL (MUL_BITS bits per iteration),
// branch resolution and exception pass-through. ex_busy asks the stall
// controller to freeze ID/EX for the duration of a multiply.
module ex_stage #(
    parameter int MUL_BITS = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_at_mem,
    input  logic        flush_at_mem,
    input  logic [31:0] id_readData1,
    input  logic [31:0] id_readData2,
    input  logic [31:0] id_address,
    input  logic [1:0]  id_aluCtrl,
    input  logic [7:0]  id_ctrl,
    input  logic        id_ignore_op2,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_pc,
    input  logic        id_exception,
    input  logic [31:0] id_faulty_addr,
    input  logic        id_iret,
    input  logic        id_tlb_write,
    output logic        ex_busy,
    output logic [31:0] ex_aluResult,
    output logic [31:0] ex_writeData,
    output logic [4:0]  ex_writeReg,
    output logic [5:0]  ex_ctrl,
    output logic        ex_tlb_write,
    output logic        ex_br_taken,
    output logic [31:0] ex_br_target,
    output logic        ex_exception,
    output logic [31:0] ex_faulty_addr,
    output logic [31:0] ex_pc
);

    localparam int N  = 32 / MUL_BITS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [31:0]   acc_reg, acc_next;
    logic [31:0]   mcand_reg, mcand_next;
    logic [31:0]   mplier_reg, mplier_next;
    logic          busy_comb;
    logic          load_bubble;
    logic          load_mul;

    // id_ctrl = {regDst,branch,memRead,memToReg,memWrite,aluSrc,regWrite,word}
    logic ctrl_regdst, ctrl_branch, ctrl_memread, ctrl_memtoreg;
    logic ctrl_memwrite, ctrl_alusrc, ctrl_regwrite, ctrl_word;
    assign {ctrl_regdst, ctrl_branch, ctrl_memread, ctrl_memtoreg,
            ctrl_memwrite, ctrl_alusrc, ctrl_regwrite, ctrl_word} = id_ctrl;

    logic [31:0] op_a, op_b;
    logic [31:0] alu_result;
    logic        mul_start;
    logic        br_taken;
    logic [31:0] br_target;

    assign op_a      = id_readData1;
    assign op_b      = id_ignore_op2 ? 32'h0 : (ctrl_alusrc ? id_address : id_readData2);
    assign mul_start = (id_aluCtrl == 2'b10) && !id_exception;
    assign br_taken  = ctrl_branch && (id_readData1 == id_readData2) && !id_exception;
    assign br_target = id_pc + 32'd4 + {id_address[29:0], 2'b00};

    // Single-cycle ALU; MUL yields 0 here because its result comes from the accumulator
    always_comb begin
        alu_result = '0;
        case (id_aluCtrl)
            2'b00:   alu_result = op_a + op_b;
            2'b01:   alu_result = op_a - op_b;
            2'b11:   alu_result = {31'b0, $signed(op_a) < $signed(op_b)};
            default: alu_result = '0;
        endcase
    end

    // Partial product of the low multiplier digit, pre-shifted for every iteration slot
    logic [31:0] pp;
    logic [31:0] pp_shift [2**CW];
    assign pp = 32'(mplier_reg[MUL_BITS-1:0]) * mcand_reg;

    generate
        for (genvar gi = 0; gi < 2**CW; gi++) begin : g_pp_shift
            assign pp_shift[gi] = pp << (gi * MUL_BITS);
        end
    endgenerate

    // Multiplier FSM state and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
        end
    end

    // Next-state, busy and output-register load selection; flush beats stall
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        busy_comb   = 1'b0;
        load_bubble = 1'b0;
        load_mul    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (mul_start) begin
                    busy_comb   = 1'b1;
                    load_bubble = 1'b1;
                    mcand_next  = op_a;
                    mplier_next = op_b;
                    acc_next    = '0;
                    cnt_next    = '0;
                    state_next  = RUN;
                end
            end
            RUN: begin
                busy_comb   = 1'b1;
                load_bubble = 1'b1;
                acc_next    = acc_reg + pp_shift[cnt_reg];
                mplier_next = mplier_reg >> MUL_BITS;
                cnt_next    = cnt_reg + CW'(1);
                if (cnt_reg == CNT_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                load_mul   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (flush_at_mem) begin
            state_next = IDLE;
            acc_next   = '0;
            cnt_next   = '0;
        end else if (stall_at_mem) begin
            state_next  = state_reg;
            cnt_next    = cnt_reg;
            acc_next    = acc_reg;
            mcand_next  = mcand_reg;
            mplier_next = mplier_reg;
        end
    end

    assign ex_busy = busy_comb && !reset;

    // EX/MEM pipeline register: bubble on flush or while multiplying, hold on stall
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_aluResult   <= '0;
            ex_writeData   <= '0;
            ex_writeReg    <= '0;
            ex_ctrl        <= '0;
            ex_tlb_write   <= 1'b0;
            ex_br_taken    <= 1'b0;
            ex_br_target   <= '0;
            ex_exception   <= 1'b0;
            ex_faulty_addr <= '0;
            ex_pc          <= '0;
        end else if (flush_at_mem || (!stall_at_mem && load_bubble)) begin
            ex_aluResult   <= '0;
            ex_writeData   <= '0;
            ex_writeReg    <= '0;
            ex_ctrl        <= '0;
            ex_tlb_write   <= 1'b0;
            ex_br_taken    <= 1'b0;
            ex_br_target   <= '0;
            ex_exception   <= 1'b0;
            ex_faulty_addr <= '0;
            ex_pc          <= '0;
        end else if (!stall_at_mem) begin
            ex_aluResult   <= load_mul ? acc_reg : alu_result;
            ex_writeData   <= id_readData2;
            ex_writeReg    <= ctrl_regdst ? id_rd : id_rt;
            ex_ctrl        <= {ctrl_memread && !id_exception, ctrl_memtoreg,
                               ctrl_memwrite && !id_exception, ctrl_regwrite && !id_exception,
                               ctrl_word, id_iret};
            ex_tlb_write   <= id_tlb_write;
            ex_br_taken    <= br_taken;
            ex_br_target   <= br_target;
            ex_exception   <= id_exception;
            ex_faulty_addr <= id_faulty_addr;
            ex_pc          <= id_pc;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: scoreboard of expected EX/MEM contents, pushed at issue
// and popped when the stage delivers the result.
module tb_ex_stage;

    localparam int NITER = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall_at_mem, flush_at_mem;
    logic [31:0] id_readData1, id_readData2, id_address;
    logic [1:0]  id_aluCtrl;
    logic [7:0]  id_ctrl;
    logic        id_ignore_op2;
    logic [4:0]  id_rt, id_rd;
    logic [31:0] id_pc;
    logic        id_exception;
    logic [31:0] id_faulty_addr;
    logic        id_iret, id_tlb_write;
    logic        ex_busy;
    logic [31:0] ex_aluResult, ex_writeData;
    logic [4:0]  ex_writeReg;
    logic [5:0]  ex_ctrl;
    logic        ex_tlb_write, ex_br_taken;
    logic [31:0] ex_br_target;
    logic        ex_exception;
    logic [31:0] ex_faulty_addr, ex_pc;

    ex_stage #(.MUL_BITS(8)) dut (
        .clock(clock), .reset(reset),
        .stall_at_mem(stall_at_mem), .flush_at_mem(flush_at_mem),
        .id_readData1(id_readData1), .id_readData2(id_readData2),
        .id_address(id_address), .id_aluCtrl(id_aluCtrl), .id_ctrl(id_ctrl),
        .id_ignore_op2(id_ignore_op2), .id_rt(id_rt), .id_rd(id_rd),
        .id_pc(id_pc), .id_exception(id_exception), .id_faulty_addr(id_faulty_addr),
        .id_iret(id_iret), .id_tlb_write(id_tlb_write),
        .ex_busy(ex_busy), .ex_aluResult(ex_aluResult), .ex_writeData(ex_writeData),
        .ex_writeReg(ex_writeReg), .ex_ctrl(ex_ctrl), .ex_tlb_write(ex_tlb_write),
        .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
        .ex_exception(ex_exception), .ex_faulty_addr(ex_faulty_addr), .ex_pc(ex_pc)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] alu;
        logic        alu_chk;
        logic [31:0] wdata;
        logic [4:0]  wreg;
        logic [5:0]  ctrl;
        logic        tlb;
        logic        br;
        logic [31:0] tgt;
        logic        exc;
        logic [31:0] faddr;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [7:0] ctrl,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] pc,
                         input logic exc, input logic ign);
        id_aluCtrl     = op;
        id_readData1   = a;
        id_readData2   = b;
        id_address     = imm;
        id_ctrl        = ctrl;
        id_rt          = rt;
        id_rd          = rd;
        id_pc          = pc;
        id_exception   = exc;
        id_ignore_op2  = ign;
        id_faulty_addr = pc ^ 32'hA5A5_0000;
        id_iret        = rt[0];
        id_tlb_write   = rd[0];
    endtask

    // Reference behaviour of the instruction currently on the ID/EX inputs
    function automatic exp_t model_op();
        exp_t        e;
        logic [31:0] ob;
        ob = id_ignore_op2 ? 32'h0 : (id_ctrl[2] ? id_address : id_readData2);
        case (id_aluCtrl)
            2'b00:   e.alu = id_readData1 + ob;
            2'b01:   e.alu = id_readData1 - ob;
            2'b10:   e.alu = id_readData1 * ob;
            default: e.alu = ($signed(id_readData1) < $signed(ob)) ? 32'd1 : 32'd0;
        endcase
        e.alu_chk = !(id_aluCtrl == 2'b10 && id_exception);
        e.wdata   = id_readData2;
        e.wreg    = id_ctrl[7] ? id_rd : id_rt;
        e.ctrl    = {id_ctrl[5] & ~id_exception, id_ctrl[4], id_ctrl[3] & ~id_exception,
                     id_ctrl[1] & ~id_exception, id_ctrl[0], id_iret};
        e.tlb     = id_tlb_write;
        e.br      = id_ctrl[6] && (id_readData1 == id_readData2) && !id_exception;
        e.tgt     = id_pc + 32'd4 + (id_address << 2);
        e.exc     = id_exception;
        e.faddr   = id_faulty_addr;
        e.pc      = id_pc;
        return e;
    endfunction

    task automatic pop_check(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        if (e.alu_chk) check({tag, "_alu"}, ex_aluResult, e.alu);
        check({tag, "_wdata"}, ex_writeData, e.wdata);
        check({tag, "_wreg"}, 32'(ex_writeReg), 32'(e.wreg));
        check({tag, "_ctrl"}, 32'(ex_ctrl), 32'(e.ctrl));
        check({tag, "_tlb"}, 32'(ex_tlb_write), 32'(e.tlb));
        check({tag, "_br"}, 32'(ex_br_taken), 32'(e.br));
        check({tag, "_tgt"}, ex_br_target, e.tgt);
        check({tag, "_exc"}, 32'(ex_exception), 32'(e.exc));
        check({tag, "_faddr"}, ex_faulty_addr, e.faddr);
        check({tag, "_pc"}, ex_pc, e.pc);
        $display("[TB] %s op=%0d A=%08h B=%08h -> res=%08h", tag, id_aluCtrl,
                 id_readData1, id_readData2, ex_aluResult);
    endtask

    // Issue the driven instruction (called at a falling edge) and check its result
    task automatic run_op(input string tag);
        int cyc;
        sb.push_back(model_op());
        #1;
        if (id_aluCtrl == 2'b10 && !id_exception) begin
            cyc = 0;
            while (ex_busy && cyc < 20) begin
                cyc++;
                @(negedge clock);
                check({tag, "_bubble_ctrl"}, 32'({ex_ctrl, ex_exception, ex_br_taken}), 32'd0);
                check({tag, "_bubble_alu"}, ex_aluResult, 32'd0);
            end
            check({tag, "_busy_cycles"}, 32'(cyc), 32'(NITER + 1));
        end else begin
            check({tag, "_busy_low"}, 32'(ex_busy), 32'd0);
        end
        @(negedge clock);
        pop_check(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t ex_hold;
        reset        = 1'b1;
        stall_at_mem = 1'b0;
        flush_at_mem = 1'b0;
        drive(2'b00, 0, 0, 0, 8'h00, 0, 0, 0, 1'b0, 1'b0);
        #12;
        check("reset_busy", 32'(ex_busy), 32'd0);
        check("reset_alu", ex_aluResult, 32'd0);
        check("reset_ctrl", 32'(ex_ctrl), 32'd0);
        check("reset_pc", ex_pc, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // ADD wrap-around
        drive(2'b00, 32'hFFFF_FFFF, 32'd1, 0, 8'b0000_0010, 5'd3, 5'd9, 32'h40, 1'b0, 1'b0);
        run_op("add_wrap");
        check("add_wrap_spec", ex_aluResult, 32'd0);

        // SLT signed
        drive(2'b11, 32'hFFFF_FFFF, 32'd1, 0, 8'b1000_0010, 5'd3, 5'd9, 32'h44, 1'b0, 1'b0);
        run_op("slt_neg");
        check("slt_neg_spec", ex_aluResult, 32'd1);

        // MUL with known product
        drive(2'b10, 32'h0001_0003, 32'h0000_0005, 0, 8'b0000_0010, 5'd4, 5'd5, 32'h48, 1'b0, 1'b0);
        run_op("mul_spec");
        check("mul_spec_value", ex_aluResult, 32'h0005_000F);

        // BEQ backward target
        drive(2'b01, 32'd7, 32'd7, 32'hFFFF_FFFF, 8'b0100_0000, 5'd0, 5'd0, 32'h100, 1'b0, 1'b0);
        run_op("beq");
        check("beq_taken", 32'(ex_br_taken), 32'd1);
        check("beq_target", ex_br_target, 32'h0000_0100);

        // Flush during the second RUN cycle
        drive(2'b10, 32'd3, 32'd4, 0, 8'b0000_0010, 5'd6, 5'd7, 32'h200, 1'b0, 1'b0);
        #1 check("flush_busy_issue", 32'(ex_busy), 32'd1);
        @(negedge clock);
        @(negedge clock);
        flush_at_mem = 1'b1;
        drive(2'b00, 32'd1, 32'd2, 0, 8'b0010_1010, 5'd8, 5'd9, 32'h204, 1'b0, 1'b0);
        @(negedge clock);
        check("flush_busy", 32'(ex_busy), 32'd0);
        check("flush_ctrl", 32'(ex_ctrl), 32'd0);
        check("flush_alu", ex_aluResult, 32'd0);
        check("flush_pc", ex_pc, 32'd0);
        flush_at_mem = 1'b0;
        drive(2'b00, 32'd1, 32'd2, 0, 8'b0000_0010, 5'd8, 5'd9, 32'h204, 1'b0, 1'b0);
        run_op("after_flush");

        // Stall holds the register for three cycles
        drive(2'b00, 32'd100, 32'd23, 0, 8'b0000_0010, 5'd10, 5'd11, 32'h300, 1'b0, 1'b0);
        ex_hold = model_op();
        run_op("stall_pre");
        drive(2'b01, 32'd50, 32'd8, 0, 8'b1000_0010, 5'd12, 5'd13, 32'h304, 1'b0, 1'b0);
        sb.push_back(model_op());
        stall_at_mem = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check($sformatf("stall_hold%0d_alu", i), ex_aluResult, ex_hold.alu);
            check($sformatf("stall_hold%0d_pc", i), ex_pc, ex_hold.pc);
        end
        stall_at_mem = 1'b0;
        @(negedge clock);
        pop_check("stall_release");

        // Exception on a MUL: never starts, write-enables suppressed
        drive(2'b10, 32'd9, 32'd9, 0, 8'b0010_1010, 5'd14, 5'd15, 32'h400, 1'b1, 1'b0);
        run_op("exc_mul");
        check("exc_mul_flag", 32'(ex_exception), 32'd1);

        // Asynchronous reset in the middle of a multiply
        drive(2'b10, 32'd5, 32'd6, 0, 8'b0000_0010, 5'd1, 5'd2, 32'h500, 1'b0, 1'b0);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("areset_busy", 32'(ex_busy), 32'd0);
        check("areset_alu", ex_aluResult, 32'd0);
        check("areset_ctrl", 32'(ex_ctrl), 32'd0);
        drive(2'b00, 0, 0, 0, 8'h00, 0, 0, 0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        // Random mix, including back-to-back multiplies
        for (int i = 0; i < 24; i++) begin
            drive(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 8'($urandom),
                  5'($urandom), 5'($urandom), $urandom, 1'b0, ($urandom_range(0, 3) == 0));
            run_op($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
